inst_mem_arbiter: RTL and testbench

- Shares one single-port, read-only instruction memory between two requesters:
  - port 0: instruction fetch (IF);
  - port 1: data-side constant load (DM).
- The memory is a synchronous ROM: address is registered on the edge at the end of the grant cycle, and data appears MEM_LATENCY cycles later.
- The arbiter grants round-robin at up to one access per cycle and tags each access in flight, so every response goes back to its owner.
- It also supports an IF flush (branch redirect) that discards fetch responses still in flight.

---
 rtl/inst_mem_arbiter_pkg.sv | 42 ++++
 rtl/inst_mem_arb_tag_pipe.sv | 66 ++++++
 rtl/inst_mem_arbiter.sv | 107 ++++++++++
 tb/tb_inst_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// inst_mem_arbiter_pkg
// Shared constants and types for the instruction-memory arbiter.
//   - Bus widths and memory enable/zero-word constants of the instruction side.
//   - Owner encoding of an in-flight access (IF = 0, DM = 1).
//   - tag_t: one {valid, owner} entry of the in-flight tag pipeline.
//   - clamp_latency(): folds a latency parameter into the legal 1..4 range.
// -----------------------------------------------------------------------------
package inst_mem_arbiter_pkg;

  localparam int InstructionAddressBus = 32;
  localparam int InstructionBus        = 32;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam logic [InstructionBus-1:0] ZeroWord = '0;

  localparam logic ArbOwnerIF = 1'b0;
  localparam logic ArbOwnerDM = 1'b1;

  localparam int MemLatencyMax = 4;

  typedef enum logic {
    OWNER_IF = ArbOwnerIF,
    OWNER_DM = ArbOwnerDM
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  // Out-of-range latencies are folded to the nearest legal depth so the
  // pipeline never degenerates to zero stages.
  function automatic int clamp_latency(input int lat);
    if (lat < 1) return 1;
    if (lat > MemLatencyMax) return MemLatencyMax;
    return lat;
  endfunction

endpackage

// File: rtl/inst_mem_arb_tag_pipe.sv
// -----------------------------------------------------------------------------
// inst_mem_arb_tag_pipe
// Shift register of {valid, owner} tags, one stage per cycle of memory
// latency. The last stage lines up with the cycle in which the memory
// presents the read data for that access.
//
// Ports:
//   clk, rst      clock / asynchronous active-high reset
//   load_valid    a grant is being issued this cycle
//   load_owner    owner of that grant
//   kill_if       clear every IF-owned entry at this edge (fetch flush)
//   slot_valid    response slot holds a live access
//   slot_owner    owner of the response slot
//   busy          any stage holds a live access
// -----------------------------------------------------------------------------
module inst_mem_arb_tag_pipe
  import inst_mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load_valid,
  input  owner_e load_owner,
  input  logic   kill_if,
  output logic   slot_valid,
  output owner_e slot_owner,
  output logic   busy
);

  localparam int Depth = clamp_latency(MEM_LATENCY);

  tag_t             stage_reg [Depth];
  logic [Depth-1:0] valid_vec;

  // A flush drops IF entries as they move into the next stage; DM entries
  // pass through untouched.
  function automatic tag_t apply_kill(input tag_t t, input logic kill);
    tag_t r;
    r = t;
    if (kill && (t.owner == OWNER_IF)) r.valid = 1'b0;
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        stage_reg[i] <= '{valid: 1'b0, owner: OWNER_IF};
      end
    end else begin
      stage_reg[0] <= apply_kill('{valid: load_valid, owner: load_owner}, kill_if);
      for (int i = 1; i < Depth; i++) begin
        stage_reg[i] <= apply_kill(stage_reg[i-1], kill_if);
      end
    end
  end

  for (genvar gi = 0; gi < Depth; gi++) begin : g_valid
    assign valid_vec[gi] = stage_reg[gi].valid;
  end

  assign slot_valid = stage_reg[Depth-1].valid;
  assign slot_owner = stage_reg[Depth-1].owner;
  assign busy       = |valid_vec;

endmodule

// File: rtl/inst_mem_arbiter.sv
// -----------------------------------------------------------------------------
// inst_mem_arbiter
// Round-robin arbiter sharing one synchronous instruction ROM between the
// fetch port (IF) and the data-side constant-load port (DM). Each granted
// access is tagged with its owner so the response, MEM_LATENCY cycles later,
// is routed back to the right port. An IF flush drops fetches still in flight.
//
// Ports:
//   clk, rst                      clock / asynchronous active-high reset
//   if_req, if_addr, if_flush     fetch request, byte address, redirect flush
//   if_gnt, if_rvalid, if_rdata   fetch grant and response
//   dm_req, dm_addr               data read request and byte address
//   dm_gnt, dm_rvalid, dm_rdata   data read grant and response
//   mem_ce, mem_addr, mem_rdata   ROM interface (data forwarded combinationally)
//   busy                          at least one access in flight
// -----------------------------------------------------------------------------
module inst_mem_arbiter
  import inst_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = InstructionAddressBus,
  parameter int DATA_W      = InstructionBus,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_ce,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  owner_e last_grant_reg;
  owner_e last_grant_next;
  logic   if_elig;
  logic   dm_elig;
  logic   grant_valid;
  owner_e grant_owner;
  logic   slot_valid;
  owner_e slot_owner;

  // Grant decision. Requests are masked while reset is high so every output
  // reads zero immediately on an asynchronous reset, not just after an edge.
  always_comb begin
    if_gnt          = 1'b0;
    dm_gnt          = 1'b0;
    if_elig         = if_req & ~if_flush & ~rst;
    dm_elig         = dm_req & ~rst;

    if (if_elig && dm_elig) begin
      // Tie: the port that was not served last goes first.
      if (last_grant_reg == OWNER_DM) if_gnt = 1'b1;
      else                            dm_gnt = 1'b1;
    end else if (if_elig) begin
      if_gnt = 1'b1;
    end else if (dm_elig) begin
      dm_gnt = 1'b1;
    end

    grant_valid     = if_gnt | dm_gnt;
    grant_owner     = dm_gnt ? OWNER_DM : OWNER_IF;
    last_grant_next = grant_valid ? grant_owner : last_grant_reg;

    mem_ce          = grant_valid ? ChipEnable : ChipDisable;
    mem_addr        = '0;
    if (if_gnt)      mem_addr = if_addr;
    else if (dm_gnt) mem_addr = dm_addr;
  end

  // Reset to DM so that IF wins the first tie after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_reg <= OWNER_DM;
    else     last_grant_reg <= last_grant_next;
  end

  inst_mem_arb_tag_pipe #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .load_valid (grant_valid),
    .load_owner (grant_owner),
    .kill_if    (if_flush),
    .slot_valid (slot_valid),
    .slot_owner (slot_owner),
    .busy       (busy)
  );

  // A flush also hides an IF response landing in the flush cycle itself,
  // since the pipeline kill only takes effect at the following edge.
  assign if_rvalid = slot_valid & (slot_owner == OWNER_IF) & ~if_flush;
  assign dm_rvalid = slot_valid & (slot_owner == OWNER_DM);

  assign if_rdata  = if_rvalid ? mem_rdata : DATA_W'(ZeroWord);
  assign dm_rdata  = dm_rvalid ? mem_rdata : DATA_W'(ZeroWord);

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_inst_mem_arbiter
// Three arbiter instances (MEM_LATENCY 1, 2, 3), each with its own ROM model.
// Directed stimulus pushes expected responses {instance, port, data, cycle}
// into a queue; a negedge monitor pops and compares every response.
// -----------------------------------------------------------------------------
module tb_inst_mem_arbiter;

  localparam int N = 3;

  typedef struct {
    int          inst;
    logic        port;   // 0 = IF, 1 = DM
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        exp_q [$];

  logic        if_req    [N];
  logic [31:0] if_addr   [N];
  logic        if_flush  [N];
  logic        if_gnt    [N];
  logic        if_rvalid [N];
  logic [31:0] if_rdata  [N];
  logic        dm_req    [N];
  logic [31:0] dm_addr   [N];
  logic        dm_gnt    [N];
  logic        dm_rvalid [N];
  logic [31:0] dm_rdata  [N];
  logic        mem_ce    [N];
  logic [31:0] mem_addr  [N];
  logic        busy      [N];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM contents: word index in the low half, fixed marker in the high half.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[17:2]};
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int Lat = gi + 1;
    logic [31:0] rd_pipe [Lat];

    inst_mem_arbiter #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .MEM_LATENCY (Lat)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req[gi]),
      .if_addr   (if_addr[gi]),
      .if_flush  (if_flush[gi]),
      .if_gnt    (if_gnt[gi]),
      .if_rvalid (if_rvalid[gi]),
      .if_rdata  (if_rdata[gi]),
      .dm_req    (dm_req[gi]),
      .dm_addr   (dm_addr[gi]),
      .dm_gnt    (dm_gnt[gi]),
      .dm_rvalid (dm_rvalid[gi]),
      .dm_rdata  (dm_rdata[gi]),
      .mem_ce    (mem_ce[gi]),
      .mem_addr  (mem_addr[gi]),
      .mem_rdata (rd_pipe[Lat-1]),
      .busy      (busy[gi])
    );

    // Synchronous ROM: address captured at the grant edge, data Lat cycles on.
    always @(posedge clk) begin
      rd_pipe[0] <= mem_ce[gi] ? rom(mem_addr[gi]) : 32'hDEAD_DEAD;
      for (int i = 1; i < Lat; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic mon_port(input int k, input logic port, input logic rv, input logic [31:0] rd);
    exp_t e;
    n_checks++;
    if (rv === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp: inst %0d port %0d data %h cycle %0d, required no response",
                 k, port, rd, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.inst != k || e.port !== port || e.data !== rd || e.due != cyc) begin
          n_fail++;
          $display("FAIL rsp_mismatch: got inst %0d port %0d data %h cycle %0d, required inst %0d port %0d data %h cycle %0d",
                   k, port, rd, cyc, e.inst, e.port, e.data, e.due);
        end else begin
          $display("rsp ok: inst %0d port %0d data %h cycle %0d", k, port, rd, cyc);
        end
      end
    end else if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL rdata_idle: inst %0d port %0d got %h, required 0", k, port, rd);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int k = 0; k < N; k++) begin
        mon_port(k, 1'b0, if_rvalid[k], if_rdata[k]);
        mon_port(k, 1'b1, dm_rvalid[k], dm_rdata[k]);
      end
    end
  end

  task automatic push(input int k, input logic port, input logic [31:0] a, input int due);
    exp_t e;
    e.inst = k;
    e.port = port;
    e.data = rom(a);
    e.due  = due;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int k = 0; k < N; k++) begin
      if_req[k]   = 1'b0;
      if_addr[k]  = 32'h0;
      if_flush[k] = 1'b0;
      dm_req[k]   = 1'b0;
      dm_addr[k]  = 32'h0;
    end
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic check_port(input int k, input string name, input logic e_if,
                            input logic e_dm, input logic [31:0] e_addr);
    check({name, "_if_gnt"},   if_gnt[k],   e_if);
    check({name, "_dm_gnt"},   dm_gnt[k],   e_dm);
    check({name, "_mem_ce"},   mem_ce[k],   e_if | e_dm);
    check({name, "_mem_addr"}, mem_addr[k], e_addr);
    $display("txn %s: inst %0d cycle %0d if_gnt %0b dm_gnt %0b mem_addr %h",
             name, k, cyc, if_gnt[k], dm_gnt[k], mem_addr[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ia;
    logic [31:0] da;
    logic        exp_if;

    idle_all();
    rst = 1'b1;
    #5;
    // Reset state on the L=1 instance while reset is held.
    check("rst_if_gnt",    if_gnt[0],    1'b0);
    check("rst_mem_ce",    mem_ce[0],    1'b0);
    check("rst_mem_addr",  mem_addr[0],  32'h0);
    check("rst_busy",      busy[0],      1'b0);
    check("rst_if_rvalid", if_rvalid[0], 1'b0);
    check("rst_dm_rvalid", dm_rvalid[0], 1'b0);
    check("rst_if_rdata",  if_rdata[0],  32'h0);
    step();
    step();

    // Single IF fetch, L=1.
    do_reset();
    step();
    if_req[0] = 1'b1; if_addr[0] = 32'h8;
    mid();
    check_port(0, "single_if", 1'b1, 1'b0, 32'h8);
    push(0, 1'b0, 32'h8, cyc + 1);
    step();
    if_req[0] = 1'b0; if_addr[0] = 32'h0;
    mid();
    check_port(0, "single_idle", 1'b0, 1'b0, 32'h0);
    step(); step(); step();

    // Contention from the first cycle after reset, L=1: IF, DM, IF, DM ...
    do_reset();
    ia = 32'h100; da = 32'h200;
    for (int i = 0; i < 8; i++) begin
      if_req[0] = 1'b1; if_addr[0] = ia;
      dm_req[0] = 1'b1; dm_addr[0] = da;
      mid();
      exp_if = ((i % 2) == 0);
      check_port(0, "contention", exp_if, ~exp_if, exp_if ? ia : da);
      push(0, ~exp_if, exp_if ? ia : da, cyc + 1);
      step();
      if (exp_if) ia = ia + 32'h4;
      else        da = da + 32'h4;
    end
    idle_all();
    step(); step(); step();

    // Latency sweep, L=3: IF, DM, IF back-to-back; busy window follows.
    do_reset();
    step();
    for (int i = 0; i < 7; i++) begin
      idle_all();
      if (i == 0) begin if_req[2] = 1'b1; if_addr[2] = 32'h40; end
      if (i == 1) begin dm_req[2] = 1'b1; dm_addr[2] = 32'h80; end
      if (i == 2) begin if_req[2] = 1'b1; if_addr[2] = 32'h44; end
      mid();
      check("sweep_busy", busy[2], (i >= 1) && (i <= 5));
      case (i)
        0: begin check_port(2, "sweep", 1'b1, 1'b0, 32'h40); push(2, 1'b0, 32'h40, cyc + 3); end
        1: begin check_port(2, "sweep", 1'b0, 1'b1, 32'h80); push(2, 1'b1, 32'h80, cyc + 3); end
        2: begin check_port(2, "sweep", 1'b1, 1'b0, 32'h44); push(2, 1'b0, 32'h44, cyc + 3); end
        default: check_port(2, "sweep_idle", 1'b0, 1'b0, 32'h0);
      endcase
      step();
    end

    // Flush, L=3: two fetches killed in flight, DM survives, next fetch normal.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      idle_all();
      case (i)
        0: begin if_req[2] = 1'b1; if_addr[2] = 32'h300; end
        1: begin if_req[2] = 1'b1; if_addr[2] = 32'h304; end
        2: begin
          if_req[2] = 1'b1; if_addr[2] = 32'h308; if_flush[2] = 1'b1;
          dm_req[2] = 1'b1; dm_addr[2] = 32'hA00;
        end
        3: begin if_req[2] = 1'b1; if_addr[2] = 32'h308; end
        default: ;
      endcase
      mid();
      case (i)
        0: check_port(2, "flush_if0", 1'b1, 1'b0, 32'h300);
        1: check_port(2, "flush_if1", 1'b1, 1'b0, 32'h304);
        2: begin check_port(2, "flush_dm", 1'b0, 1'b1, 32'hA00); push(2, 1'b1, 32'hA00, cyc + 3); end
        3: begin check_port(2, "flush_if2", 1'b1, 1'b0, 32'h308); push(2, 1'b0, 32'h308, cyc + 3); end
        default: ;
      endcase
      step();
    end

    // Flush landing on the response cycle, L=1: IF response hidden, DM proceeds.
    do_reset();
    if_req[0] = 1'b1; if_addr[0] = 32'h500;
    mid();
    check_port(0, "flush_rsp_if", 1'b1, 1'b0, 32'h500);
    step();
    idle_all();
    if_flush[0] = 1'b1; dm_req[0] = 1'b1; dm_addr[0] = 32'h900;
    mid();
    check("flush_rsp_if_rvalid", if_rvalid[0], 1'b0);
    check_port(0, "flush_rsp_dm", 1'b0, 1'b1, 32'h900);
    push(0, 1'b1, 32'h900, cyc + 1);
    step();
    idle_all();
    step(); step();

    // Reset mid-flight, L=2: DM access lost, first tie afterwards goes to IF.
    do_reset();
    dm_req[1] = 1'b1; dm_addr[1] = 32'h600;
    mid();
    check_port(1, "rstmid_dm", 1'b0, 1'b1, 32'h600);
    step();
    if_req[1] = 1'b1; if_addr[1] = 32'h610;
    dm_req[1] = 1'b1; dm_addr[1] = 32'h620;
    #2;
    rst = 1'b1;
    #2;
    check("rstmid_if_gnt",    if_gnt[1],    1'b0);
    check("rstmid_dm_gnt",    dm_gnt[1],    1'b0);
    check("rstmid_mem_ce",    mem_ce[1],    1'b0);
    check("rstmid_mem_addr",  mem_addr[1],  32'h0);
    check("rstmid_busy",      busy[1],      1'b0);
    check("rstmid_if_rvalid", if_rvalid[1], 1'b0);
    check("rstmid_dm_rvalid", dm_rvalid[1], 1'b0);
    check("rstmid_dm_rdata",  dm_rdata[1],  32'h0);
    #2;
    rst = 1'b0;
    mid();
    check_port(1, "rstmid_tie", 1'b1, 1'b0, 32'h610);
    push(1, 1'b0, 32'h610, cyc + 2);
    step();
    idle_all();
    step(); step(); step(); step();

    // Withdraw, L=1: DM asks for one cycle while IF wins, then drops.
    do_reset();
    if_req[0] = 1'b1; if_addr[0] = 32'h700;
    dm_req[0] = 1'b1; dm_addr[0] = 32'h800;
    mid();
    check_port(0, "withdraw_tie", 1'b1, 1'b0, 32'h700);
    push(0, 1'b0, 32'h700, cyc + 1);
    step();
    idle_all();
    mid();
    check_port(0, "withdraw_idle1", 1'b0, 1'b0, 32'h0);
    step();
    mid();
    check_port(0, "withdraw_idle2", 1'b0, 1'b0, 32'h0);
    step(); step(); step();

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
